bin_to_bcd_seq: RTL and testbench

Parametrised, handshaked binary-to-BCD converter. It performs an iterative shift-add-3 (double-dabble) conversion with one bit per clock, so logic depth stays at a single add-3 stage for any width. Optional signed mode outputs sign plus magnitude. It adds overflow saturation and leading-zero information for display drivers. It sits between measurement/counter blocks and the seven-segment/LCD formatting logic, and replaces fixed 16-bit/5-digit divider pipelines wherever width or digit count differs.

---
 rtl/bin_to_bcd_seq.sv | 163 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with valid/ready
// handshakes, optional sign-magnitude input, overflow saturation and leading-zero info.
module bin_to_bcd_seq #(
  parameter int unsigned IN_WIDTH   = 16,
  parameter int unsigned BCD_DIGITS = 5,
  parameter bit          SIGNED_EN  = 1'b0,
  localparam int unsigned CNT_W     = $clog2(BCD_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     bin_in,
  input  logic                    signed_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*BCD_DIGITS-1:0] bcd_out,
  output logic                    neg,
  output logic                    overflow,
  output logic [CNT_W-1:0]        digit_cnt,
  output logic [BCD_DIGITS-1:0]   blank_mask
);

  localparam int unsigned BW     = 4 * BCD_DIGITS;
  localparam int unsigned STEP_W = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StConvert, StFinal, StDone} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   mag_q, mag_d, mag_c;
  logic [BW-1:0]         acc_q, acc_d, adj;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  sticky_q, sticky_d;
  logic                  neg_r_q, neg_r_d, neg_c;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  neg_q, neg_d, ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_c;
  logic [BCD_DIGITS-1:0] blank_q, blank_d, blank_c;

  always_comb begin
    mag_c = bin_in;
    neg_c = 1'b0;
    if (SIGNED_EN && signed_mode && bin_in[IN_WIDTH-1]) begin
      mag_c = ~bin_in + {{(IN_WIDTH-1){1'b0}}, 1'b1};
      neg_c = 1'b1;
    end
  end

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i+:4] >= 4'd5) adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
    end
  end

  always_comb begin
    cnt_c = CNT_W'(1);
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_q[4*i+:4] != 4'd0) cnt_c = CNT_W'(i + 1);
    end
    for (int i = 0; i < BCD_DIGITS; i++) begin
      blank_c[i] = (CNT_W'(i) >= cnt_c);
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    step_d      = step_q;
    sticky_d    = sticky_q;
    neg_r_d     = neg_r_q;
    bcd_d       = bcd_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    blank_d     = blank_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d    = mag_c;
          neg_r_d  = neg_c;
          acc_d    = '0;
          step_d   = '0;
          sticky_d = 1'b0;
          state_d  = StConvert;
        end
      end
      StConvert: begin
        acc_d    = {adj[BW-2:0], mag_q[IN_WIDTH-1]};
        mag_d    = {mag_q[IN_WIDTH-2:0], 1'b0};
        sticky_d = sticky_q | adj[BW-1];
        step_d   = step_q + STEP_W'(1);
        if (step_q == STEP_W'(IN_WIDTH - 1)) state_d = StFinal;
      end
      StFinal: begin
        if (sticky_q) begin
          bcd_d   = {BCD_DIGITS{4'h9}};
          cnt_d   = CNT_W'(BCD_DIGITS);
          blank_d = '0;
          ovf_d   = 1'b1;
        end else begin
          bcd_d   = acc_q;
          cnt_d   = cnt_c;
          blank_d = blank_c;
          ovf_d   = 1'b0;
        end
        // A zero magnitude never reports negative.
        neg_d       = neg_r_q && (sticky_q || (acc_q != '0));
        out_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mag_q       <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      sticky_q    <= 1'b0;
      neg_r_q     <= 1'b0;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= CNT_W'(1);
      blank_q     <= ~BCD_DIGITS'(1);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      sticky_q    <= sticky_d;
      neg_r_q     <= neg_r_d;
      bcd_q       <= bcd_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = out_valid_q;
  assign bcd_out    = bcd_q;
  assign neg        = neg_q;
  assign overflow   = ovf_q;
  assign digit_cnt  = cnt_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench: three converter instances (unsigned 5-digit, signed 5-digit, unsigned 4-digit) driven
// in lockstep and compared against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        signed_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] bin_in = '0;

  logic        rdy0, rdy1, rdy2, val0, val1, val2;
  logic [19:0] bcd0, bcd1;
  logic [15:0] bcd2;
  logic        neg0, neg1, neg2, ovf0, ovf1, ovf2;
  logic [2:0]  cnt0, cnt1, cnt2;
  logic [4:0]  blank0, blank1;
  logic [3:0]  blank2;

  int n_chk = 0;
  int n_err = 0;

  logic [39:0] o_bcd [3];
  logic [7:0]  o_cnt [3];
  logic [9:0]  o_blank [3];
  logic        o_neg [3], o_ovf [3], o_val [3], o_rdy [3];

  logic [39:0] x_bcd [3];
  logic [9:0]  x_blank [3];
  bit          x_neg [3], x_ovf [3];
  int          x_cnt [3];

  bin_to_bcd_seq #(.IN_WIDTH(16), .BCD_DIGITS(5), .SIGNED_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .bin_in(bin_in),
    .signed_mode(signed_mode), .out_valid(val0), .out_ready(out_ready), .bcd_out(bcd0),
    .neg(neg0), .overflow(ovf0), .digit_cnt(cnt0), .blank_mask(blank0));

  bin_to_bcd_seq #(.IN_WIDTH(16), .BCD_DIGITS(5), .SIGNED_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .bin_in(bin_in),
    .signed_mode(signed_mode), .out_valid(val1), .out_ready(out_ready), .bcd_out(bcd1),
    .neg(neg1), .overflow(ovf1), .digit_cnt(cnt1), .blank_mask(blank1));

  bin_to_bcd_seq #(.IN_WIDTH(16), .BCD_DIGITS(4), .SIGNED_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .bin_in(bin_in),
    .signed_mode(signed_mode), .out_valid(val2), .out_ready(out_ready), .bcd_out(bcd2),
    .neg(neg2), .overflow(ovf2), .digit_cnt(cnt2), .blank_mask(blank2));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Decimal reference: plain division on the magnitude.
  function automatic void model(input logic [15:0] b, input bit sm, input bit sen, input int nd,
                                output logic [39:0] bcd, output bit ng, output bit ov,
                                output int cnt, output logic [9:0] blank);
    longint mag, lim, t;
    mag = (sen && sm && b[15]) ? (65536 - longint'(b)) : longint'(b);
    lim = 1;
    repeat (nd) lim = lim * 10;
    ov  = (mag >= lim);
    ng  = sen && sm && b[15] && (mag != 0);
    bcd = '0;
    cnt = 1;
    t   = mag;
    for (int i = 0; i < nd; i++) begin
      if (ov) bcd[4*i+:4] = 4'd9;
      else begin
        bcd[4*i+:4] = 4'(t % 10);
        if (t % 10 != 0) cnt = i + 1;
        t = t / 10;
      end
    end
    if (ov) cnt = nd;
    blank = '0;
    for (int i = 0; i < nd; i++) if (i >= cnt) blank[i] = 1'b1;
  endfunction

  task automatic capture();
    o_bcd[0] = {20'd0, bcd0}; o_bcd[1] = {20'd0, bcd1}; o_bcd[2] = {24'd0, bcd2};
    o_cnt[0] = {5'd0, cnt0};  o_cnt[1] = {5'd0, cnt1};  o_cnt[2] = {5'd0, cnt2};
    o_blank[0] = {5'd0, blank0}; o_blank[1] = {5'd0, blank1}; o_blank[2] = {6'd0, blank2};
    o_neg[0] = neg0; o_neg[1] = neg1; o_neg[2] = neg2;
    o_ovf[0] = ovf0; o_ovf[1] = ovf1; o_ovf[2] = ovf2;
    o_val[0] = val0; o_val[1] = val1; o_val[2] = val2;
    o_rdy[0] = rdy0; o_rdy[1] = rdy1; o_rdy[2] = rdy2;
  endtask

  // One handshaked conversion, entered and left at a falling edge.
  task automatic do_conversion(input string tag, input logic [15:0] v, input bit sm,
                               input int hold, input bit poke);
    int w, lat;
    for (int k = 0; k < 3; k++)
      model(v, sm, k == 1, (k == 2) ? 4 : 5, x_bcd[k], x_neg[k], x_ovf[k], x_cnt[k], x_blank[k]);
    w = 0;
    while (rdy0 !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    n_chk++;
    if (w >= 10) begin n_err++; $display("FAIL %s in_ready: got %b want 1", tag, rdy0); end
    bin_in = v; signed_mode = sm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (val0 !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_chk++;
    if (lat != 17) begin n_err++; $display("FAIL %s latency: got %0d want 17", tag, lat); end
    capture();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (o_val[k] !== 1'b1 || o_bcd[k] !== x_bcd[k] || o_neg[k] !== x_neg[k] ||
          o_ovf[k] !== x_ovf[k] || o_cnt[k] !== 8'(x_cnt[k]) || o_blank[k] !== x_blank[k]) begin
        n_err++;
        $display("FAIL %s dut%0d in=%h sm=%0d: got v=%b bcd=%h neg=%b ovf=%b cnt=%0d blank=%b, want v=1 bcd=%h neg=%0d ovf=%0d cnt=%0d blank=%b",
                 tag, k, v, sm, o_val[k], o_bcd[k], o_neg[k], o_ovf[k], o_cnt[k], o_blank[k],
                 x_bcd[k], x_neg[k], x_ovf[k], x_cnt[k], x_blank[k]);
      end
    end
    if (out_ready) begin
      @(negedge clk);
      n_chk++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
        n_err++;
        $display("FAIL %s one-cycle valid: got valid=%b ready=%b want 0/1", tag, val0, rdy0);
      end
    end else begin
      for (int c = 0; c < hold; c++) begin
        if (poke) begin bin_in = ~v; in_valid = 1'b1; end
        @(negedge clk);
        capture();
        for (int k = 0; k < 3; k++) begin
          n_chk++;
          if (o_val[k] !== 1'b1 || o_rdy[k] !== 1'b0 || o_bcd[k] !== x_bcd[k] ||
              o_cnt[k] !== 8'(x_cnt[k]) || o_blank[k] !== x_blank[k]) begin
            n_err++;
            $display("FAIL %s hold dut%0d cyc%0d: got v=%b rdy=%b bcd=%h want v=1 rdy=0 bcd=%h",
                     tag, k, c, o_val[k], o_rdy[k], o_bcd[k], x_bcd[k]);
          end
        end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_chk++;
      if (val0 !== 1'b0 || rdy0 !== 1'b1) begin
        n_err++;
        $display("FAIL %s release: got valid=%b ready=%b want 0/1", tag, val0, rdy0);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      capture();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (o_val[k] !== 1'b0 || o_rdy[k] !== 1'b1 || o_bcd[k] !== 40'd0 || o_neg[k] !== 1'b0 ||
            o_ovf[k] !== 1'b0 || o_cnt[k] !== 8'd1 ||
            o_blank[k] !== ((k == 2) ? 10'b1110 : 10'b11110)) begin
          n_err++;
          $display("FAIL reset dut%0d pass%0d: got v=%b rdy=%b bcd=%h neg=%b ovf=%b cnt=%0d blank=%b",
                   k, pass, o_val[k], o_rdy[k], o_bcd[k], o_neg[k], o_ovf[k], o_cnt[k], o_blank[k]);
        end
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    do_conversion("12345", 16'd12345, 1'b0, 1, 1'b0);
    n_chk++;
    if (o_bcd[0] !== 40'h12345) begin
      n_err++; $display("FAIL literal_12345: got %h want 12345", o_bcd[0]);
    end
    do_conversion("zero", 16'd0, 1'b0, 0, 1'b0);
    do_conversion("max", 16'hFFFF, 1'b0, 2, 1'b0);
    do_conversion("neg1", 16'hFFFF, 1'b1, 0, 1'b0);
    do_conversion("minneg", 16'h8000, 1'b1, 1, 1'b0);
    do_conversion("9999", 16'd9999, 1'b0, 0, 1'b0);
    do_conversion("10000", 16'd10000, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_conversion("random", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic test_backpressure();
    do_conversion("backpressure", 16'($urandom_range(0, 65535)), 1'b1, 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      do_conversion("b2b", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 0, 1'b0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    bin_in = 16'($urandom_range(1000, 65535)); signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    capture();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (o_val[k] !== 1'b0 || o_rdy[k] !== 1'b1 || o_bcd[k] !== 40'd0 || o_cnt[k] !== 8'd1 ||
          o_blank[k] !== ((k == 2) ? 10'b1110 : 10'b11110)) begin
        n_err++;
        $display("FAIL reset_mid dut%0d: got v=%b rdy=%b bcd=%h cnt=%0d blank=%b",
                 k, o_val[k], o_rdy[k], o_bcd[k], o_cnt[k], o_blank[k]);
      end
    end
    seen = 0;
    repeat (25) begin @(negedge clk); if (val0 !== 1'b0) seen++; end
    n_chk++;
    if (seen != 0) begin n_err++; $display("FAIL reset_mid no_result: got %0d valid cycles want 0", seen); end
    do_conversion("after_reset_42", 16'd42, 1'b0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
